// File: rtl/acc_cpu_pkg.sv
// rtl/acc_cpu_pkg.sv - shared opcode/state types for the accumulator CPU
package acc_cpu_pkg;

    localparam int OPC_W = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_IN    = 3'b100,
        OP_JZ    = 3'b101,
        OP_JPOS  = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        LOAD_MODE  = 3'd0,
        FETCH      = 3'd1,
        DECODE     = 3'd2,
        EXECUTE    = 3'd3,
        INPUT_WAIT = 3'd4,
        HALTED     = 3'd5
    } state_t;

endpackage

// File: rtl/acc_cpu_alu.sv
// rtl/acc_cpu_alu.sv - add/sub and accumulator flags; ACC_CPU_SAT_EN selects signed saturation
module acc_cpu_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              pos
);

`ifdef ACC_CPU_SAT_EN
    logic [DATA_W:0] ext_sum;
    logic            overflow;

    // Sign-extended add/sub; clamp to the signed extreme on overflow
    always_comb begin
        if (sub) begin
            ext_sum = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        end else begin
            ext_sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        end
        overflow = ext_sum[DATA_W] ^ ext_sum[DATA_W-1];
        if (!overflow) begin
            result = ext_sum[DATA_W-1:0];
        end else if (ext_sum[DATA_W]) begin
            result = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            result = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    // Plain modular add/sub
    always_comb begin
        if (sub) begin
            result = a - b;
        end else begin
            result = a + b;
        end
    end
`endif

    // A > 0 means strictly positive as a signed value
    assign zero = (a == '0);
    assign pos  = ~a[DATA_W-1] & ~zero;

endmodule

// File: rtl/acc_cpu_param.sv
// rtl/acc_cpu_param.sv - parameterised accumulator CPU top; ACC_CPU_SAT_EN enables saturating ADD/SUB
module acc_cpu_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enter,
    input  logic [DATA_W-1:0] Input,
    input  logic              programEn,
    input  logic              ProgWr,
    input  logic [ADDR_W-1:0] ProgAddr,
    output logic              Halt,
    output logic [DATA_W-1:0] Output
);
    import acc_cpu_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [ADDR_W-1:0] pc;
    opcode_t           ir_op;
    logic [ADDR_W-1:0] ir_addr;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] acc;
    logic              halt_r;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_pos;

    acc_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (acc),
        .b      (operand),
        .sub    (ir_op == OP_SUB),
        .result (alu_result),
        .zero   (alu_zero),
        .pos    (alu_pos)
    );

    // Single write port: program load in LOAD_MODE, STORE in EXECUTE unless being abandoned
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ProgAddr;
        mem_wdata = Input;
        if (state == LOAD_MODE) begin
            mem_we = ProgWr;
        end else if (state == EXECUTE && ir_op == OP_STORE && !programEn) begin
            mem_we    = 1'b1;
            mem_waddr = ir_addr;
            mem_wdata = acc;
        end
    end

    // Memory array is not reset; a pending STORE is dropped while Reset is high
    always_ff @(posedge Clock) begin
        if (mem_we && !Reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM: fetch / decode / execute with operator input wait and program-load override
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= FETCH;
            pc      <= '0;
            ir_op   <= OP_LOAD;
            ir_addr <= '0;
            operand <= '0;
            acc     <= '0;
            halt_r  <= 1'b0;
        end else if (programEn) begin
            state  <= LOAD_MODE;
            pc     <= '0;
            halt_r <= 1'b0;
        end else begin
            halt_r <= 1'b0;
            case (state)
                LOAD_MODE: begin
                    state <= FETCH;
                    pc    <= '0;
                end
                FETCH: begin
                    ir_op   <= opcode_t'(mem[pc][DATA_W-1 -: OPC_W]);
                    ir_addr <= mem[pc][ADDR_W-1:0];
                    pc      <= pc + ADDR_W'(1);
                    state   <= DECODE;
                end
                DECODE: begin
                    operand <= mem[ir_addr];
                    case (ir_op)
                        OP_IN:   state <= INPUT_WAIT;
                        OP_HALT: begin
                            state  <= HALTED;
                            halt_r <= 1'b1;
                        end
                        default: state <= EXECUTE;
                    endcase
                end
                EXECUTE: begin
                    state <= FETCH;
                    case (ir_op)
                        OP_LOAD: acc <= operand;
                        OP_ADD,
                        OP_SUB:  acc <= alu_result;
                        OP_JZ:   if (alu_zero) pc <= ir_addr;
                        OP_JPOS: if (alu_pos)  pc <= ir_addr;
                        default: ;
                    endcase
                end
                INPUT_WAIT: begin
                    if (Enter) begin
                        acc   <= Input;
                        state <= FETCH;
                    end
                end
                HALTED: begin
                    halt_r <= 1'b1;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign Output = acc;
    assign Halt   = halt_r;

endmodule

// File: tb/tb_acc_cpu_param.sv
// tb/tb_acc_cpu_param.sv - self-checking bench for acc_cpu_param against an instruction-level model
module tb_acc_cpu_param;
    import acc_cpu_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Enter = 1'b0;
    logic [7:0]  Input = '0;
    logic        programEn = 1'b0;
    logic        ProgWr = 1'b0;
    logic [4:0]  ProgAddr = '0;
    logic        Halt;
    logic [7:0]  Output;

    int checks = 0;
    int errors = 0;

    logic [7:0] prog  [DEPTH];
    logic [7:0] m_mem [DEPTH];
    int         m_a;
    int         m_cycles;

    acc_cpu_param #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Enter     (Enter),
        .Input     (Input),
        .programEn (programEn),
        .ProgWr    (ProgWr),
        .ProgAddr  (ProgAddr),
        .Halt      (Halt),
        .Output    (Output)
    );

    always #5 Clock = ~Clock;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    function automatic logic [7:0] ins(input int op, input int addr);
        return 8'((op << 5) | (addr & 31));
    endfunction

    // Signed add/sub on 8-bit values, wrapping or clamping by build option
    function automatic int arith(input int a, input int b, input bit sub);
        int sa;
        int sb;
        int r;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        r  = sub ? sa - sb : sa + sb;
`ifdef ACC_CPU_SAT_EN
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
`endif
        return r & 255;
    endfunction

    // Instruction-level interpreter; cycle cost: 1 to leave load mode, 3 per instruction, 2 for HALT
    task automatic model_run(input int a0, input int in_val);
        int pc;
        int steps;
        int op;
        int ad;
        bit done;
        pc = 0; steps = 0; done = 0;
        m_a = a0;
        m_cycles = 1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = prog[i];
        while (!done && steps < 1000) begin
            op = int'(m_mem[pc]) >> 5;
            ad = int'(m_mem[pc]) & 31;
            pc = (pc + 1) % DEPTH;
            steps++;
            if (op == 7) begin
                done = 1;
                m_cycles += 2;
            end else begin
                m_cycles += 3;
                case (op)
                    0: m_a = int'(m_mem[ad]);
                    1: m_mem[ad] = 8'(m_a);
                    2: m_a = arith(m_a, int'(m_mem[ad]), 1'b0);
                    3: m_a = arith(m_a, int'(m_mem[ad]), 1'b1);
                    4: m_a = in_val;
                    5: if (m_a == 0) pc = ad;
                    6: if (m_a >= 1 && m_a <= 127) pc = ad;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < DEPTH; i++) prog[i] = 8'h00;
    endtask

    // Reset with programEn held so the first edge lands in LOAD_MODE
    task automatic reset_into_load();
        @(negedge Clock);
        Reset = 1'b1; programEn = 1'b1; ProgWr = 1'b0; Enter = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic load_image();
        for (int i = 0; i < DEPTH; i++) begin
            ProgWr = 1'b1; ProgAddr = 5'(i); Input = prog[i];
            @(negedge Clock);
        end
        ProgWr = 1'b0;
    endtask

    task automatic start_run(input logic [7:0] in_val, input logic ent);
        programEn = 1'b0; Input = in_val; Enter = ent;
    endtask

    task automatic wait_halt(input int budget, output int n);
        n = 0;
        while (Halt !== 1'b1 && n < budget) begin
            @(posedge Clock); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        @(negedge Clock);
        Reset = 1'b1; programEn = 1'b0; Enter = 1'b0; ProgWr = 1'b0;
        #2;
        checks++; if (Output !== 8'h00) begin errors++; $display("FAIL reset_output: got %0h expected 0", Output); end
        checks++; if (Halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %0b expected 0", Halt); end
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        checks++; if (dut.pc !== 5'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", dut.pc); end
        checks++; if (dut.state !== FETCH) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state, FETCH); end
    endtask

    task automatic test_add_store();
        int n;
        clear_prog();
        prog[0] = ins(4, 0); prog[1] = ins(2, 6); prog[2] = ins(1, 7); prog[3] = ins(7, 0); prog[6] = 8'd5;
        reset_into_load();
        load_image();
        start_run(8'd3, 1'b0);
        repeat (8) @(negedge Clock);
        checks++; if (Halt !== 1'b0 || Output !== 8'h00) begin errors++; $display("FAIL in_wait_hold: got halt=%0b out=%0h expected 0/0", Halt, Output); end
        Enter = 1'b1;
        @(negedge Clock);
        Enter = 1'b0;
        checks++; if (Output !== 8'd3) begin errors++; $display("FAIL in_value: got %0d expected 3", Output); end
        wait_halt(50, n);
        checks++; if (Halt !== 1'b1) begin errors++; $display("FAIL add_store_halt: got %0b expected 1", Halt); end
        checks++; if (n != 8) begin errors++; $display("FAIL add_store_cycles: got %0d expected 8", n); end
        checks++; if (Output !== 8'd8) begin errors++; $display("FAIL add_store_out: got %0d expected 8", Output); end
        checks++; if (dut.mem[7] !== 8'd8) begin errors++; $display("FAIL add_store_mem: got %0d expected 8", dut.mem[7]); end
    endtask

    task automatic test_countdown();
        int n;
        clear_prog();
        prog[0] = ins(4, 0); prog[1] = ins(3, 5); prog[2] = ins(6, 1); prog[3] = ins(7, 0); prog[5] = 8'd1;
        reset_into_load();
        load_image();
        start_run(8'd4, 1'b1);
        wait_halt(100, n);
        checks++; if (Halt !== 1'b1) begin errors++; $display("FAIL countdown_halt: got %0b expected 1", Halt); end
        checks++; if (n != 30) begin errors++; $display("FAIL countdown_cycles: got %0d expected 30", n); end
        checks++; if (Output !== 8'd0) begin errors++; $display("FAIL countdown_out: got %0d expected 0", Output); end
    endtask

    task automatic test_overflow();
        int n;
        logic [7:0] exp_add;
        logic [7:0] exp_sub;
`ifdef ACC_CPU_SAT_EN
        exp_add = 8'h7F; exp_sub = 8'h80;
`else
        exp_add = 8'h80; exp_sub = 8'h7F;
`endif
        clear_prog();
        prog[0] = ins(4, 0); prog[1] = ins(2, 6); prog[2] = ins(7, 0); prog[6] = 8'd1;
        reset_into_load();
        load_image();
        start_run(8'd127, 1'b1);
        wait_halt(50, n);
        checks++; if (Halt !== 1'b1 || Output !== exp_add) begin errors++; $display("FAIL ovf_add: got %0h expected %0h", Output, exp_add); end
        prog[1] = ins(3, 6);
        reset_into_load();
        load_image();
        start_run(8'h80, 1'b1);
        wait_halt(50, n);
        checks++; if (Halt !== 1'b1 || Output !== exp_sub) begin errors++; $display("FAIL ovf_sub: got %0h expected %0h", Output, exp_sub); end
    endtask

    task automatic test_arith_random();
        int n;
        int in_val;
        bit sub;
        for (int t = 0; t < 12; t++) begin
            clear_prog();
            sub = 1'($urandom_range(0, 1));
            in_val = int'($urandom_range(0, 255));
            prog[0] = ins(4, 0); prog[1] = ins(sub ? 3 : 2, 6); prog[2] = ins(7, 0);
            prog[6] = 8'($urandom_range(0, 255));
            reset_into_load();
            load_image();
            model_run(0, in_val);
            start_run(8'(in_val), 1'b1);
            wait_halt(50, n);
            checks++; if (Halt !== 1'b1 || Output !== 8'(m_a)) begin errors++; $display("FAIL arith_rand: in=%0h m=%0h sub=%0b got %0h expected %0h", in_val, prog[6], sub, Output, 8'(m_a)); end
        end
    endtask

    task automatic test_pc_wrap();
        int n;
        clear_prog();
        prog[0] = ins(5, 30); prog[1] = ins(7, 0); prog[29] = 8'd5; prog[30] = ins(2, 29); prog[31] = ins(2, 29);
        reset_into_load();
        load_image();
        start_run(8'd0, 1'b0);
        wait_halt(100, n);
        checks++; if (Halt !== 1'b1) begin errors++; $display("FAIL wrap_halt: got %0b expected 1", Halt); end
        checks++; if (n != 15) begin errors++; $display("FAIL wrap_cycles: got %0d expected 15", n); end
        checks++; if (Output !== 8'd10) begin errors++; $display("FAIL wrap_out: got %0d expected 10", Output); end
    endtask

    task automatic test_reset_abort();
        clear_prog();
        prog[0] = ins(0, 8); prog[1] = ins(4, 0); prog[2] = ins(1, 7); prog[3] = ins(7, 0);
        prog[7] = 8'h55; prog[8] = 8'h33;
        reset_into_load();
        load_image();
        start_run(8'h2A, 1'b0);
        repeat (8) @(negedge Clock);
        checks++; if (Output !== 8'h33) begin errors++; $display("FAIL abort_pre_out: got %0h expected 33", Output); end
        Reset = 1'b1;
        #1;
        checks++; if (Output !== 8'h00 || dut.pc !== 5'd0) begin errors++; $display("FAIL abort_wait: got out=%0h pc=%0d expected 0/0", Output, dut.pc); end
        @(negedge Clock);
        Reset = 1'b0; Enter = 1'b1; Input = 8'h2A;
        repeat (8) @(negedge Clock);
        checks++; if (Output !== 8'h2A || dut.state !== EXECUTE) begin errors++; $display("FAIL abort_pre_store: got out=%0h state=%0d expected 2a/%0d", Output, dut.state, EXECUTE); end
        Reset = 1'b1;
        @(negedge Clock);
        checks++; if (dut.mem[7] !== 8'h55) begin errors++; $display("FAIL abort_store_mem: got %0h expected 55", dut.mem[7]); end
        checks++; if (Output !== 8'h00 || dut.pc !== 5'd0) begin errors++; $display("FAIL abort_store_regs: got out=%0h pc=%0d expected 0/0", Output, dut.pc); end
        Reset = 1'b0; Enter = 1'b0;
    endtask

    task automatic test_reload_halted();
        int n;
        clear_prog();
        prog[0] = ins(4, 0); prog[1] = ins(2, 6); prog[2] = ins(1, 7); prog[3] = ins(7, 0); prog[6] = 8'd5;
        reset_into_load();
        load_image();
        start_run(8'd3, 1'b1);
        wait_halt(50, n);
        checks++; if (Halt !== 1'b1 || Output !== 8'd8) begin errors++; $display("FAIL reload_first: got halt=%0b out=%0d expected 1/8", Halt, Output); end
        @(negedge Clock);
        programEn = 1'b1; Enter = 1'b0;
        @(posedge Clock); #1;
        checks++; if (Halt !== 1'b0 || Output !== 8'd8) begin errors++; $display("FAIL reload_enter: got halt=%0b out=%0d expected 0/8", Halt, Output); end
        @(negedge Clock);
        ProgWr = 1'b1; ProgAddr = 5'd6; Input = 8'd10;
        @(negedge Clock);
        ProgWr = 1'b0;
        start_run(8'd3, 1'b1);
        wait_halt(50, n);
        checks++; if (n != 12) begin errors++; $display("FAIL reload_cycles: got %0d expected 12", n); end
        checks++; if (Halt !== 1'b1 || Output !== 8'd13) begin errors++; $display("FAIL reload_out: got halt=%0b out=%0d expected 1/13", Halt, Output); end
        checks++; if (dut.mem[7] !== 8'd13) begin errors++; $display("FAIL reload_mem: got %0d expected 13", dut.mem[7]); end
    endtask

    // Random forward-only programs in 0..15, data in 16..31, HALT at 15
    task automatic test_random_programs();
        int n;
        int op;
        int in_val;
        for (int t = 0; t < 25; t++) begin
            clear_prog();
            for (int i = 0; i < 15; i++) begin
                op = int'($urandom_range(0, 6));
                if (op == 5 || op == 6) prog[i] = ins(op, int'($urandom_range(i + 1, 15)));
                else prog[i] = ins(op, int'($urandom_range(16, 31)));
            end
            prog[15] = ins(7, 0);
            for (int i = 16; i < 32; i++) prog[i] = 8'($urandom_range(0, 255));
            in_val = int'($urandom_range(0, 255));
            reset_into_load();
            load_image();
            model_run(0, in_val);
            start_run(8'(in_val), 1'b1);
            wait_halt(200, n);
            checks++; if (Halt !== 1'b1) begin errors++; $display("FAIL rand_halt: prog %0d got %0b expected 1", t, Halt); end
            checks++; if (n != m_cycles) begin errors++; $display("FAIL rand_cycles: prog %0d got %0d expected %0d", t, n, m_cycles); end
            checks++; if (Output !== 8'(m_a)) begin errors++; $display("FAIL rand_out: prog %0d got %0h expected %0h", t, Output, 8'(m_a)); end
            for (int k = 16; k < 32; k++) begin
                checks++; if (dut.mem[k] !== m_mem[k]) begin errors++; $display("FAIL rand_mem: prog %0d addr %0d got %0h expected %0h", t, k, dut.mem[k], m_mem[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_store();
        test_countdown();
        test_overflow();
        test_arith_random();
        test_pc_wrap();
        test_reset_abort();
        test_reload_halted();
        test_random_programs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_cpu_param.md
ACC_CPU_PARAM -- requirements
Module: acc_cpu_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: accumulator, memory-word and I/O width (legal range 8..32).
REQ-002 SHALL have parameter ADDR_W, default 5: memory address width; memory depth = 2**ADDR_W words; ADDR_W <= DATA_W-3.
REQ-003 SHALL have port Clock  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Enter  input  1  level-sensitive operator strobe that completes an IN instruction.
REQ-006 SHALL have port Input  input  DATA_W  operand for IN; program word when loading.
REQ-007 SHALL have port programEn  input  1  program-load mode; suspends execution.
REQ-008 SHALL have port ProgWr  input  1  write strobe for program load.
REQ-009 SHALL have port ProgAddr  input  ADDR_W  program-load write address.
REQ-010 SHALL have port Halt  output  1  high while in HALTED.
REQ-011 SHALL have port Output  output  DATA_W  registered accumulator value A.

Function
REQ-012 Instruction word SHALL be DATA_W bits: opcode = bits [DATA_W-1:DATA_W-3], address = bits [ADDR_W-1:0]; other bits ignored.
REQ-013 Opcodes SHALL be: 000 LOAD A<=M[a]; 001 STORE M[a]<=A; 010 ADD A<=A+M[a]; 011 SUB A<=A-M[a]; 100 IN A<=Input; 101 JZ PC<=a if A==0; 110 JPOS PC<=a if A>0 (signed: nonzero and MSB 0); 111 HALT.
REQ-014 Memory SHALL use asynchronous read and synchronous write, with a single write port shared by STORE and program load.
REQ-015 FSM states SHALL be LOAD_MODE, FETCH, DECODE, EXECUTE, INPUT_WAIT and HALTED.
REQ-016 FETCH (1 cycle): IR<=M[PC], PC<=PC+1 modulo 2**ADDR_W (wraps from max to 0); next state DECODE.
REQ-017 DECODE (1 cycle): latch the operand M[IR.a]; next state INPUT_WAIT for IN, HALTED for HALT, otherwise EXECUTE.
REQ-018 EXECUTE (1 cycle): perform the opcode; next state FETCH. Each non-IN instruction SHALL take exactly 3 cycles.
REQ-019 INPUT_WAIT: hold until Enter=1 is sampled; on that edge A<=Input and next state FETCH; IN SHALL take a minimum of 3 cycles.
REQ-020 A taken jump SHALL overwrite the PC increment from FETCH; an untaken jump SHALL leave PC unchanged.
REQ-021 HALTED SHALL be exited only by Reset or programEn=1.
REQ-022 programEn=1 in any state SHALL force LOAD_MODE on the next edge, abandon the current instruction (no A or memory update) and hold PC at 0.
REQ-023 In LOAD_MODE, ProgWr=1 SHALL write M[ProgAddr]<=Input each cycle; ProgWr SHALL be ignored outside LOAD_MODE.
REQ-024 When programEn falls, the FSM SHALL go to FETCH with PC=0 and A unchanged.
REQ-025 Output SHALL equal A at all times; Halt SHALL be 1 exactly while the state is HALTED.

Reset
REQ-026 Reset SHALL asynchronously set state FETCH, PC=0, IR=0, A=0 (Output=0, Halt=0); memory contents SHALL NOT be reset.
REQ-027 Reset asserted mid-instruction or in INPUT_WAIT SHALL abort the instruction with no memory write.

Configuration
REQ-028 With macro ACC_CPU_SAT_EN defined, ADD/SUB SHALL saturate as signed values to 2**(DATA_W-1)-1 or -2**(DATA_W-1).
REQ-029 Without ACC_CPU_SAT_EN, ADD/SUB SHALL wrap modulo 2**DATA_W.

Structure
REQ-030 Shared package acc_cpu_pkg SHALL hold the opcode enum, the FSM state enum and OPC_W=3.
REQ-031 Add/sub and flag logic (A==0, A>0, saturation) SHALL be in sub-module acc_cpu_alu, parameterised by DATA_W.

Verification
REQ-032 Load program {0:IN,1:ADD 6,2:STORE 7,3:HALT,6:5}, Input=3, pulse Enter -> M[7]=8, Output=8, Halt=1.
REQ-033 Countdown program (IN; SUB one; JPOS back; HALT) with Input=4 -> JPOS taken 3 times, Halt at A=0, 3 cycles per non-IN instruction.
REQ-034 DATA_W=8, A=127, ADD M[a]=1 -> Output=128 (0x80) without ACC_CPU_SAT_EN, 127 with it; A=-128, SUB 1 -> 127 wrap, -128 saturated.
REQ-035 Program of non-jump instructions at the last address (2**ADDR_W-1) -> PC wraps to 0 and fetches M[0].
REQ-036 Reset asserted in INPUT_WAIT and during a STORE EXECUTE -> A=0, PC=0, target word unchanged.
REQ-037 programEn raised while HALTED, word rewritten, programEn dropped -> Halt=0 next cycle, execution restarts at PC=0.
